// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions: opcodes, ALU operations, trap causes and the
// registered decode payload carried from decode to execute.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [2:0] F3_SYS_RSVD = 3'b100;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;

  localparam logic [3:0] CAUSE_NONE       = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL      = 4'd11;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    alu_op_e     alu_op;
    logic [3:0]  trap_cause;
    logic [11:0] csr_addr;
    logic        is_csr;
    logic        csr_read;
    logic        csr_write;
    logic        trap;
    logic        reg_write_enable;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        jump;
    logic        use_pc;
  } dec_t;

  // Register-register and register-immediate ALU ops share one funct3 map;
  // only the register form may select SUB.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    alu_op_e op;
    op = ALU_NONE;
    case (f3)
      3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idecode_imm_gen.sv
// Immediate generator: selects the instruction format from the opcode and
// returns the XLEN-wide immediate (CSR forms yield the zero-extended uimm).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_c
);

  logic [2:0] f3;
  assign f3 = instr[14:12];

  always_comb begin
    imm_c = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR:
        imm_c = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm_c = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm_c = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
      OPC_JAL:
        imm_c = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_c = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
      OPC_SYSTEM:
        if (f3 != F3_PRIV && f3 != F3_SYS_RSVD) imm_c = XLEN'(instr[19:15]);
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/idecode.sv
// RV64I decode stage: one registered decode per clock with stall (hold) and
// flush (bubble now plus one more bubble for the stale fetch behind it).
module idecode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] regfile_rs1,
  input  logic [XLEN-1:0] regfile_rs2,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [3:0]      alu_op,
  output logic [3:0]      trap_cause,
  output logic [11:0]     csr_addr,
  output logic            is_csr,
  output logic            csr_read,
  output logic            csr_write,
  output logic            trap,
  output logic            reg_write_enable,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            jump,
  output logic            use_pc
);

  dec_t            dec_c, dec_d, dec_q;
  logic [XLEN-1:0] imm_c, imm_d, imm_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            flush_pending_d, flush_pending_q;
  logic [2:0]      f3;
  logic            rf_unused;

  // Operand values pass through this stage untouched.
  assign rf_unused = ^{regfile_rs1, regfile_rs2};
  assign f3        = instr[14:12];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .imm_c (imm_c)
  );

  always_comb begin
    dec_c            = '0;
    dec_c.opcode     = instr[6:0];
    dec_c.rd         = instr[11:7];
    dec_c.rs1        = instr[19:15];
    dec_c.rs2        = instr[24:20];
    dec_c.funct3     = f3;
    dec_c.funct7     = instr[31:25];
    dec_c.csr_addr   = instr[31:20];
    case (instr[6:0])
      OPC_OP, OPC_OP32: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.alu_op           = alu_from_f3(f3, instr[30], 1'b1);
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.alu_op           = alu_from_f3(f3, instr[30], 1'b0);
      end
      OPC_LOAD: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.mem_read         = 1'b1;
        dec_c.alu_op           = ALU_ADD;
      end
      OPC_STORE: begin
        dec_c.mem_write = 1'b1;
        dec_c.alu_op    = ALU_ADD;
      end
      OPC_BRANCH: begin
        dec_c.is_branch = 1'b1;
        dec_c.use_pc    = 1'b1;
      end
      OPC_JAL: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.jump             = 1'b1;
        dec_c.use_pc           = 1'b1;
        dec_c.alu_op           = ALU_ADD;
      end
      OPC_JALR: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.jump             = 1'b1;
        dec_c.alu_op           = ALU_ADD;
      end
      OPC_LUI: dec_c.reg_write_enable = 1'b1;
      OPC_AUIPC: begin
        dec_c.reg_write_enable = 1'b1;
        dec_c.use_pc           = 1'b1;
        dec_c.alu_op           = ALU_ADD;
      end
      OPC_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          // MRET/WFI and other privileged forms decode to no controls.
          if (instr[31:20] == SYS_ECALL) begin
            dec_c.trap       = 1'b1;
            dec_c.trap_cause = CAUSE_ECALL;
          end else if (instr[31:20] == SYS_EBREAK) begin
            dec_c.trap       = 1'b1;
            dec_c.trap_cause = CAUSE_BREAKPOINT;
          end
        end else if (f3 == F3_SYS_RSVD) begin
          dec_c.trap       = 1'b1;
          dec_c.trap_cause = CAUSE_ILLEGAL;
        end else begin
          dec_c.is_csr           = 1'b1;
          dec_c.reg_write_enable = 1'b1;
          dec_c.csr_read         = 1'b1;
          dec_c.csr_write        = (f3[1:0] == 2'b01) || (instr[19:15] != 5'd0);
        end
      end
      OPC_MISC_MEM: dec_c.trap = 1'b0;
      default: begin
        dec_c.trap       = 1'b1;
        dec_c.trap_cause = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Priority below reset: flush, then stall, then the pending post-flush bubble.
  always_comb begin
    dec_d           = dec_q;
    imm_d           = imm_q;
    pc_d            = pc_q;
    flush_pending_d = flush_pending_q;
    if (flush) begin
      dec_d           = '0;
      imm_d           = '0;
      pc_d            = '0;
      flush_pending_d = 1'b1;
    end else if (stall) begin
      flush_pending_d = flush_pending_q;
    end else if (flush_pending_q) begin
      dec_d           = '0;
      imm_d           = '0;
      pc_d            = '0;
      flush_pending_d = 1'b0;
    end else begin
      dec_d = dec_c;
      imm_d = imm_c;
      pc_d  = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q           <= '0;
      imm_q           <= '0;
      pc_q            <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      dec_q           <= dec_d;
      imm_q           <= imm_d;
      pc_q            <= pc_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign opcode           = dec_q.opcode;
  assign rd               = dec_q.rd;
  assign rs1              = dec_q.rs1;
  assign rs2              = dec_q.rs2;
  assign funct3           = dec_q.funct3;
  assign funct7           = dec_q.funct7;
  assign imm              = imm_q;
  assign pc_out           = pc_q;
  assign alu_op           = dec_q.alu_op;
  assign trap_cause       = dec_q.trap_cause;
  assign csr_addr         = dec_q.csr_addr;
  assign is_csr           = dec_q.is_csr;
  assign csr_read         = dec_q.csr_read;
  assign csr_write        = dec_q.csr_write;
  assign trap             = dec_q.trap;
  assign reg_write_enable = dec_q.reg_write_enable;
  assign mem_read         = dec_q.mem_read;
  assign mem_write        = dec_q.mem_write;
  assign is_branch        = dec_q.is_branch;
  assign jump             = dec_q.jump;
  assign use_pc           = dec_q.use_pc;

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: a table-driven decode model compared every
// cycle, plus directed instructions with hand-computed expectations.
module tb_idecode;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [3:0]  alu;
    logic [3:0]  cause;
    logic [11:0] csr;
    logic        is_csr;
    logic        csr_read;
    logic        csr_write;
    logic        trap;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jump;
    logic        use_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [63:0] pc = 64'h0;
  logic [63:0] regfile_rs1 = 64'hDEAD_BEEF_0000_0001;
  logic [63:0] regfile_rs2 = 64'hCAFE_F00D_0000_0002;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] imm, pc_out;
  logic [3:0]  alu_op, trap_cause;
  logic [11:0] csr_addr;
  logic        is_csr, csr_read, csr_write, trap, reg_write_enable;
  logic        mem_read, mem_write, is_branch, jump, use_pc;

  exp_t act;
  exp_t exp_q = '0;
  bit   fp_q = 1'b0;
  bit   started = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  idecode #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .instr(instr), .pc(pc),
    .regfile_rs1(regfile_rs1), .regfile_rs2(regfile_rs2),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .pc_out(pc_out), .alu_op(alu_op), .trap_cause(trap_cause),
    .csr_addr(csr_addr), .is_csr(is_csr), .csr_read(csr_read), .csr_write(csr_write),
    .trap(trap), .reg_write_enable(reg_write_enable), .mem_read(mem_read),
    .mem_write(mem_write), .is_branch(is_branch), .jump(jump), .use_pc(use_pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = '0;
    act.opcode = opcode;  act.rd = rd;  act.rs1 = rs1;  act.rs2 = rs2;
    act.funct3 = funct3;  act.funct7 = funct7;  act.imm = imm;  act.pc = pc_out;
    act.alu = alu_op;  act.cause = trap_cause;  act.csr = csr_addr;
    act.is_csr = is_csr;  act.csr_read = csr_read;  act.csr_write = csr_write;
    act.trap = trap;  act.rw = reg_write_enable;  act.mr = mem_read;
    act.mw = mem_write;  act.br = is_branch;  act.jump = jump;  act.use_pc = use_pc;
  end

  // What one instruction must decode to, straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p);
    exp_t        e;
    int unsigned tbl [8];
    logic [2:0]  f3;
    tbl = '{1, 6, 9, 10, 5, 7, 4, 3};
    e = '0;
    f3 = i[14:12];
    e.opcode = i[6:0];  e.rd = i[11:7];  e.rs1 = i[19:15];  e.rs2 = i[24:20];
    e.funct3 = f3;  e.funct7 = i[31:25];  e.csr = i[31:20];  e.pc = p;
    case (i[6:0])
      7'h33, 7'h3B: begin
        e.rw = 1;  e.alu = 4'(tbl[f3]);
        if (i[30] && f3 == 3'd0) e.alu = 4'd2;
        if (i[30] && f3 == 3'd5) e.alu = 4'd8;
      end
      7'h13, 7'h1B: begin
        e.rw = 1;  e.alu = 4'(tbl[f3]);
        if (i[30] && f3 == 3'd5) e.alu = 4'd8;
        e.imm = 64'($signed(i[31:20]));
      end
      7'h03: begin e.rw = 1; e.mr = 1; e.alu = 4'd1; e.imm = 64'($signed(i[31:20])); end
      7'h23: begin e.mw = 1; e.alu = 4'd1; e.imm = 64'($signed({i[31:25], i[11:7]})); end
      7'h63: begin
        e.br = 1;  e.use_pc = 1;
        e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h6F: begin
        e.rw = 1;  e.jump = 1;  e.use_pc = 1;  e.alu = 4'd1;
        e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin e.rw = 1; e.jump = 1; e.alu = 4'd1; e.imm = 64'($signed(i[31:20])); end
      7'h37: begin e.rw = 1; e.imm = 64'($signed({i[31:12], 12'h000})); end
      7'h17: begin e.rw = 1; e.use_pc = 1; e.alu = 4'd1; e.imm = 64'($signed({i[31:12], 12'h000})); end
      7'h73: begin
        if (f3 == 3'd0) begin
          if (i[31:20] == 12'd0) begin e.trap = 1; e.cause = 4'd11; end
          else if (i[31:20] == 12'd1) begin e.trap = 1; e.cause = 4'd3; end
        end else if (f3 == 3'd4) begin
          e.trap = 1;  e.cause = 4'd2;
        end else begin
          e.is_csr = 1;  e.rw = 1;  e.csr_read = 1;
          e.csr_write = (f3 == 3'd1 || f3 == 3'd5 || i[19:15] != 5'd0);
          e.imm = 64'(i[19:15]);
        end
      end
      7'h0F: ;
      default: begin e.trap = 1; e.cause = 4'd2; end
    endcase
    return e;
  endfunction

  // Reference pipeline register: reset > flush > stall > pending bubble > decode.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q = '0;  fp_q = 1'b0;
    end else if (flush) begin
      exp_q = '0;  fp_q = 1'b1;
    end else if (!stall) begin
      if (fp_q) begin exp_q = '0; fp_q = 1'b0; end
      else exp_q = model(instr, pc);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (act !== exp_q) begin
        n_err++;
        $display("FAIL model t=%0t: dut=%h want=%h", $time, act, exp_q);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [63:0] p, input logic s, input logic f);
    instr = i;  pc = p;  stall = s;  flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset_all_zero", 64'(act != '0), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step(32'h003100B3, 64'h1000, 0, 0);
    chk("add_rw", 64'(reg_write_enable), 1);  chk("add_alu", 64'(alu_op), 1);
    chk("add_imm", imm, 0);  chk("add_trap", 64'(trap), 0);
    chk("add_pc", pc_out, 64'h1000);
    step(32'h40628233, 64'h1004, 0, 0);
    chk("sub_alu", 64'(alu_op), 2);
    step(32'hFFF24193, 64'h1008, 0, 0);
    chk("xori_alu", 64'(alu_op), 5);  chk("xori_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    step(32'h00812083, 64'h100C, 0, 0);
    chk("lw_mr", 64'(mem_read), 1);  chk("lw_rw", 64'(reg_write_enable), 1);  chk("lw_imm", imm, 8);
    step(32'h00322623, 64'h1010, 0, 0);
    chk("sw_mw", 64'(mem_write), 1);  chk("sw_rw", 64'(reg_write_enable), 0);  chk("sw_imm", imm, 12);
    step(32'h00208463, 64'h1014, 0, 0);
    chk("beq_br", 64'(is_branch), 1);  chk("beq_alu", 64'(alu_op), 0);  chk("beq_imm", imm, 8);
    step(32'h008000EF, 64'h1018, 0, 0);
    chk("jal_jump", 64'(jump), 1);  chk("jal_alu", 64'(alu_op), 1);  chk("jal_imm", imm, 8);
    step(32'h123450B7, 64'h101C, 0, 0);
    chk("lui_imm", imm, 64'h1234_5000);  chk("lui_alu", 64'(alu_op), 0);
    step(32'h00001097, 64'h1020, 0, 0);
    chk("auipc_alu", 64'(alu_op), 1);  chk("auipc_use_pc", 64'(use_pc), 1);
    step(32'h300110F3, 64'h1024, 0, 0);
    chk("csrrw_is_csr", 64'(is_csr), 1);  chk("csrrw_rd", 64'(csr_read), 1);
    chk("csrrw_wr", 64'(csr_write), 1);  chk("csrrw_rw", 64'(reg_write_enable), 1);
    chk("csrrw_addr", 64'(csr_addr), 64'h300);  chk("csrrw_uimm", imm, 2);
    step(32'h300020F3, 64'h1028, 0, 0);
    chk("csrrs_x0_wr", 64'(csr_write), 0);  chk("csrrs_x0_rd", 64'(csr_read), 1);
    step(32'h00000073, 64'h102C, 0, 0);
    chk("ecall_trap", 64'(trap), 1);  chk("ecall_cause", 64'(trap_cause), 11);
    chk("ecall_rw", 64'(reg_write_enable), 0);
    step(32'h00100073, 64'h1030, 0, 0);
    chk("ebreak_cause", 64'(trap_cause), 3);
    step(32'hFFFFFFFF, 64'h1034, 0, 0);
    chk("illegal_trap", 64'(trap), 1);  chk("illegal_cause", 64'(trap_cause), 2);
    chk("illegal_imm", imm, 0);
    step(32'h40525193, 64'h1038, 0, 0);
    chk("srai_alu", 64'(alu_op), 8);
    step(32'h0000000F, 64'h103C, 0, 0);
    chk("fence_trap", 64'(trap), 0);  chk("fence_rw", 64'(reg_write_enable), 0);
    step(32'h30200073, 64'h1040, 0, 0);
    chk("mret_trap", 64'(trap), 0);
    step(32'h00004073, 64'h1044, 0, 0);
    chk("sys_f3_4_cause", 64'(trap_cause), 2);

    // Stall holds the previous load.
    step(32'h00812083, 64'h2000, 0, 0);
    step(32'h06400093, 64'h2004, 1, 0);
    chk("stall_hold_mr", 64'(mem_read), 1);  chk("stall_hold_imm", imm, 8);
    chk("stall_hold_pc", pc_out, 64'h2000);
    step(32'h06400093, 64'h2004, 0, 0);
    chk("addi_imm", imm, 64'h64);  chk("addi_mr", 64'(mem_read), 0);

    // Flush: two bubbles, then NOP decodes.
    step(32'h003100B3, 64'h3000, 0, 1);
    chk("flush_b1_rw", 64'(reg_write_enable), 0);  chk("flush_b1_alu", 64'(alu_op), 0);
    step(32'h40628233, 64'h3004, 0, 0);
    chk("flush_b2_rw", 64'(reg_write_enable), 0);  chk("flush_b2_alu", 64'(alu_op), 0);
    step(32'h00000013, 64'h3008, 0, 0);
    chk("nop_rw", 64'(reg_write_enable), 1);  chk("nop_alu", 64'(alu_op), 1);  chk("nop_imm", imm, 0);

    // Stall does not consume the pending bubble.
    step(32'h003100B3, 64'h4000, 0, 1);
    step(32'h003100B3, 64'h4004, 1, 0);
    step(32'h003100B3, 64'h4004, 0, 0);
    chk("pend_after_stall_rw", 64'(reg_write_enable), 0);
    step(32'h06400093, 64'h4008, 0, 0);
    chk("pend_done_imm", imm, 64'h64);

    // Flush beats stall.
    step(32'h00812083, 64'h5000, 0, 0);
    step(32'h003100B3, 64'h5004, 1, 1);
    chk("flush_over_stall_mr", 64'(mem_read), 0);
    step(32'h00000013, 64'h5008, 0, 0);
    chk("flush_over_stall_pend", 64'(reg_write_enable), 0);
    step(32'h00000013, 64'h500C, 0, 0);
    chk("flush_over_stall_nop", 64'(reg_write_enable), 1);

    // Asynchronous reset mid-stream.
    step(32'h00812083, 64'h6000, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_zero", 64'(act != '0), 64'd0);
    chk("async_reset_pc", pc_out, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    step(32'h003100B3, 64'h7000, 0, 0);
    chk("post_reset_add", 64'(alu_op), 1);
    step(32'h00000013, 64'h7004, 0, 0);
    step(32'h00000013, 64'h7008, 0, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
